mux_scan_sequencer: RTL

Sequencer placed directly upstream of the team's 8:1 behavioural multiplexer. It drives the multiplexer's 3-bit select, waits a programmable settle time on each channel, samples the single-bit multiplexer output, and assembles the eight samples into one 8-bit word. The word is offered downstream through a valid/ready handshake. This turns the combinational selector into a serial-to-parallel channel scanner.

---
 rtl/mux_scan_sequencer.sv | 130 +++++++++++++
 1 files changed

// File: rtl/mux_scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mux_scan_sequencer
// Purpose  : Steps an 8:1 mux select, waits SETTLE cycles per enabled channel,
//            samples y_in and offers the assembled byte on valid/ready.
//            Optional macro MUX_SCAN_CONTINUOUS_EN: rescan right after handshake.
// Revision : 1.0
// ============================================================================
module mux_scan_sequencer #(
   parameter int unsigned SETTLE = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_start,
   input  logic [7:0] i_mask,
   input  logic       i_y_in,
   output logic [2:0] o_sel,
   output logic [7:0] o_data_out,
   output logic       o_valid,
   input  logic       i_ready,
   output logic       o_busy
);

   localparam logic [3:0] c_SETTLE = 4'(SETTLE);
`ifdef MUX_SCAN_CONTINUOUS_EN
   localparam logic c_CONTINUOUS = 1'b1;
`else
   localparam logic c_CONTINUOUS = 1'b0;
`endif

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SCAN = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   state_t     r_state;
   state_t     w_state_nxt;
   logic [2:0] r_sel;
   logic [3:0] r_cnt;
   logic [7:0] r_mask;
   logic [7:0] r_word;
   logic [7:0] r_data;
   logic       r_valid;

   logic       w_chan_en;
   logic       w_slot_done;
   logic       w_last;
   logic       w_accept;
   logic       w_handshake;
   logic [7:0] w_word_nxt;

   // A masked channel finishes its slot immediately and contributes a zero bit.
   assign w_chan_en   = r_mask[r_sel];
   assign w_slot_done = (r_state == S_SCAN) && (!w_chan_en || (r_cnt == 4'd0));
   assign w_last      = (r_sel == 3'd7);
   assign w_accept    = (r_state == S_IDLE) && i_start;
   assign w_handshake = (r_state == S_HOLD) && r_valid && i_ready;
   assign w_word_nxt  = r_word | ({7'b0, w_chan_en & i_y_in} << r_sel);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (i_start) w_state_nxt = S_SCAN;
         end
         S_SCAN: begin
            if (w_slot_done && w_last) w_state_nxt = S_HOLD;
         end
         S_HOLD: begin
            if (w_handshake) begin
               if (c_CONTINUOUS) w_state_nxt = S_SCAN;
               else              w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sel   <= 3'd0;
         r_cnt   <= 4'd0;
         r_mask  <= 8'h00;
         r_word  <= 8'h00;
         r_data  <= 8'h00;
         r_valid <= 1'b0;
      end else if (w_accept) begin
         r_mask <= i_mask;
         r_sel  <= 3'd0;
         r_cnt  <= c_SETTLE;
         r_word <= 8'h00;
      end else if (r_state == S_SCAN) begin
         if (w_slot_done) begin
            if (w_last) begin
               r_data  <= w_word_nxt;
               r_valid <= 1'b1;
            end else begin
               r_word <= w_word_nxt;
               r_sel  <= r_sel + 3'd1;
               r_cnt  <= c_SETTLE;
            end
         end else begin
            r_cnt <= r_cnt - 4'd1;
         end
      end else if (w_handshake) begin
         r_valid <= 1'b0;
         r_sel   <= 3'd0;
         if (c_CONTINUOUS) begin
            r_cnt  <= c_SETTLE;
            r_word <= 8'h00;
         end
      end
   end

   assign o_sel      = r_sel;
   assign o_data_out = r_data;
   assign o_valid    = r_valid;
   assign o_busy     = (r_state != S_IDLE);

endmodule
`default_nettype wire
